// File: rtl/modulo_painel_operador_rolhas_pkg.sv
// Shared definitions for the operator cork-loading panel.
//   estado_t : panel FSM encoding, also driven out on the estado port
//   QTY_MAX  : ceiling for requested quantity plus current stock
package pbl_pkg;

  typedef enum logic [1:0] {
    EST_IDLE = 2'b00,
    EST_EDIT = 2'b01,
    EST_SEND = 2'b10,
    EST_ERRO = 2'b11
  } estado_t;

  localparam int QTY_MAX = 99;

endpackage

// File: rtl/modulo_painel_operador_rolhas_if.sv
// Cork transfer handshake between the operator panel and the bottling controller.
//   req     : transfer request, qty_out valid while high (panel -> consumer)
//   qty_out : binary quantity 0..99                      (panel -> consumer)
//   ack     : consumer acknowledge, single-cycle or level (consumer -> panel)
interface modulo_painel_operador_rolhas_if;
  logic       req;
  logic       ack;
  logic [6:0] qty_out;

  modport master (output req, output qty_out, input ack);
  modport slave  (input req, input qty_out, output ack);
endinterface

// File: rtl/modulo_painel_operador_rolhas_debouncer.sv
// Debouncer for one raw active-low pushbutton.
//   clk     : system clock
//   clr     : asynchronous active-low reset
//   i_btn_n : raw button, active-low, asynchronous to clk
//   o_pulse : one-cycle pulse per accepted press
module modulo_debouncer_botao #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic i_btn_n,
  output logic o_pulse
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_lvl;   // debounced level, 1 = released
  logic [CW-1:0] r_cnt;
  logic          r_pulse;
  logic          w_s;

  assign w_s     = r_sync[1];
  assign o_pulse = r_pulse;

  // The synchronizer loads "released", but the debounced level starts low so
  // a button held through reset must first be seen released for a full
  // window before its next press can produce a pulse.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_sync  <= 2'b11;
      r_lvl   <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn_n};
      r_pulse <= 1'b0;
      if (w_s == r_lvl) begin
        r_cnt <= '0;                       // any agreeing sample restarts the window
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_lvl   <= w_s;
        r_pulse <= ~w_s;                   // fire only on the accepted press edge
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/modulo_painel_operador_rolhas.sv
// Operator entry panel: debounces inc/conf/cancel buttons, accumulates a BCD
// cork quantity bounded by stock, and hands it off over a req/ack transfer.
//   clk, clr     : clock, asynchronous active-low reset
//   btn_*_n      : raw active-low pushbuttons (increment, confirm, cancel)
//   stock_atual  : current secondary-buffer count 0..99
//   xfer         : req / qty_out / ack transfer handshake (master side)
//   qty_d, qty_u : BCD tens / units of the quantity for the display
//   estado       : FSM state (00 IDLE, 01 EDIT, 10 SEND, 11 ERRO)
//   erro         : pulse on a rejected increment, held high in ERRO
module modulo_painel_operador_rolhas
  import pbl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                                   clk,
  input  logic                                   clr,
  input  logic                                   btn_inc_n,
  input  logic                                   btn_conf_n,
  input  logic                                   btn_canc_n,
  input  logic [6:0]                             stock_atual,
  modulo_painel_operador_rolhas_if.master        xfer,
  output logic [3:0]                             qty_d,
  output logic [3:0]                             qty_u,
  output logic [1:0]                             estado,
  output logic                                   erro
);

  estado_t    r_estado, w_estado_nxt;
  logic [6:0] r_qty;
  logic [3:0] r_qd, r_qu;
  logic [7:0] r_timer;
  logic       r_erro_pls;
  logic       w_p_inc, w_p_conf, w_p_canc;
  logic       w_inc, w_conf, w_canc;
  logic [7:0] w_sum;
  logic       w_cabe, w_timeout, w_req;

  modulo_debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .clr(clr), .i_btn_n(btn_inc_n),  .o_pulse(w_p_inc));
  modulo_debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_conf (
    .clk(clk), .clr(clr), .i_btn_n(btn_conf_n), .o_pulse(w_p_conf));
  modulo_debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_canc (
    .clk(clk), .clr(clr), .i_btn_n(btn_canc_n), .o_pulse(w_p_canc));

  // cancel > confirm > increment; losers in the same cycle are dropped
  assign w_canc = w_p_canc;
  assign w_conf = w_p_conf & ~w_p_canc;
  assign w_inc  = w_p_inc  & ~w_p_canc & ~w_p_conf;

  // 8-bit sum so 99 + 99 cannot wrap
  assign w_sum     = {1'b0, r_qty} + {1'b0, stock_atual};
  assign w_cabe    = w_sum < 8'(QTY_MAX);
  assign w_timeout = r_timer == 8'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_estado <= EST_IDLE;
    else      r_estado <= w_estado_nxt;
  end

  always_comb begin
    w_estado_nxt = r_estado;
    case (r_estado)
      EST_IDLE: if (w_inc) w_estado_nxt = EST_EDIT;
      EST_EDIT: begin
        if (w_canc)                       w_estado_nxt = EST_IDLE;
        else if (w_conf && r_qty != '0)   w_estado_nxt = EST_SEND;
      end
      EST_SEND: begin
        if (xfer.ack)       w_estado_nxt = EST_IDLE;   // ack beats timeout
        else if (w_timeout) w_estado_nxt = EST_ERRO;
      end
      EST_ERRO: if (w_canc) w_estado_nxt = EST_IDLE;
      default:  w_estado_nxt = EST_IDLE;
    endcase
  end

  always_comb begin
    w_req = (r_estado == EST_SEND);
    erro  = r_erro_pls | (r_estado == EST_ERRO);
  end

  // Quantity (binary + BCD kept in lockstep), timer and reject pulse.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_qty      <= '0;
      r_qd       <= '0;
      r_qu       <= '0;
      r_timer    <= '0;
      r_erro_pls <= 1'b0;
    end else begin
      r_erro_pls <= 1'b0;
      r_timer    <= (r_estado == EST_SEND) ? r_timer + 8'd1 : 8'd0;
      case (r_estado)
        EST_IDLE: if (w_inc) begin
          r_qty <= 7'd1;
          r_qd  <= 4'd0;
          r_qu  <= 4'd1;
        end
        EST_EDIT: begin
          if (w_canc) begin
            r_qty <= '0;
            r_qd  <= '0;
            r_qu  <= '0;
          end else if (w_inc) begin
            if (w_cabe) begin
              r_qty <= r_qty + 7'd1;
              if (r_qu == 4'd9) begin
                r_qu <= 4'd0;
                r_qd <= r_qd + 4'd1;
              end else begin
                r_qu <= r_qu + 4'd1;
              end
            end else begin
              r_erro_pls <= 1'b1;
            end
          end
        end
        EST_SEND: if (xfer.ack) begin
          r_qty <= '0;
          r_qd  <= '0;
          r_qu  <= '0;
        end
        EST_ERRO: if (w_canc) begin
          r_qty <= '0;
          r_qd  <= '0;
          r_qu  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign xfer.req     = w_req;
  assign xfer.qty_out = r_qty;
  assign qty_d        = r_qd;
  assign qty_u        = r_qu;
  assign estado       = r_estado;

endmodule
